leds_racer_frame_scheduler: RTL and testbench

//  Sequences one LED-strip refresh frame for the 4-player LEDs racer. Snapshots the player positions
//  and walks LED index 0..MAX_POS, presenting one 24-bit GRB pixel per index to the serial strip driver

---
 rtl/leds_racer_pkg.sv | 45 ++++
 rtl/leds_racer_pixel_arbiter.sv | 45 ++++
 rtl/leds_racer_frame_scheduler.sv | 129 ++++++++++++
 tb/tb_leds_racer_frame_scheduler.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/leds_racer_pkg.sv
// ---------------------------------------------------------------------------
// leds_racer_pkg
// Shared types and constants for the LEDs racer strip frame scheduler.
//   - Pixel colours (GRB, brightness 0x10)
//   - player_e : player index, also the rotating-priority encoding
//   - state_e  : frame scheduler FSM state (exported on dbg_state)
// ---------------------------------------------------------------------------
package leds_racer_pkg;

  localparam logic [23:0] COL_GREEN  = 24'h100000;
  localparam logic [23:0] COL_RED    = 24'h001000;
  localparam logic [23:0] COL_BLUE   = 24'h000010;
  localparam logic [23:0] COL_YELLOW = 24'h101000;
  localparam logic [23:0] COL_EMPTY  = 24'h000000;
  localparam logic [23:0] COL_FINISH = 24'h101010;

  typedef enum logic [1:0] {
    P_GREEN  = 2'd0,
    P_RED    = 2'd1,
    P_BLUE   = 2'd2,
    P_YELLOW = 2'd3
  } player_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SEND  = 2'd2,
    ST_LATCH = 2'd3
  } state_e;

  function automatic logic [23:0] player_colour(input player_e p);
    case (p)
      P_GREEN:  return COL_GREEN;
      P_RED:    return COL_RED;
      P_BLUE:   return COL_BLUE;
      default:  return COL_YELLOW;
    endcase
  endfunction

  // G -> R -> B -> Y -> G
  function automatic player_e next_prio(input player_e p);
    return player_e'(2'(p) + 2'd1);
  endfunction

endpackage

// File: rtl/leds_racer_pixel_arbiter.sv
// ---------------------------------------------------------------------------
// leds_racer_pixel_arbiter
// Combinational colour selection for one LED index.
//   index  in  POS_W      LED index being coloured
//   pos    in  4 x POS_W  player positions, element 0 = green .. 3 = yellow
//   prio   in  player_e   player scanned first; scan wraps G,R,B,Y
//   colour out 24         GRB pixel value
// Optional: LEDS_RACER_FINISH_MARK_EN shows a white mark on the last LED
// when no player occupies it.
// ---------------------------------------------------------------------------
module leds_racer_pixel_arbiter
  import leds_racer_pkg::*;
#(
  parameter int MAX_POS = 109,
  parameter int POS_W   = $clog2(MAX_POS + 1)
) (
  input  logic [POS_W-1:0]      index,
  input  logic [3:0][POS_W-1:0] pos,
  input  player_e               prio,
  output logic [23:0]           colour
);

  logic       found;
  logic [1:0] p;

  always_comb begin
    colour = COL_EMPTY;
    found  = 1'b0;
    p      = 2'd0;
    // Scan players starting at prio; 2-bit add gives the wrap-around.
    for (int k = 0; k < 4; k++) begin
      p = 2'(prio) + 2'(k);
      if (!found && (pos[p] == index)) begin
        colour = player_colour(player_e'(p));
        found  = 1'b1;
      end
    end
`ifdef LEDS_RACER_FINISH_MARK_EN
    if (!found && (index == POS_W'(MAX_POS))) begin
      colour = COL_FINISH;
    end
`endif
  end

endmodule

// File: rtl/leds_racer_frame_scheduler.sv
// ---------------------------------------------------------------------------
// leds_racer_frame_scheduler
// Sequences one LED-strip refresh frame: snapshot the four player positions,
// stream pixels 0..MAX_POS to the serial encoder, then hold the latch gap.
//   clk, rst        clock, asynchronous active-high reset
//   enable          1 = refresh continuously, 0 = park in IDLE after the gap
//   *_pos           player positions (sampled only in LOAD, clamped)
//   pixel_data      GRB pixel for current index (registered)
//   pixel_valid     pixel_data valid
//   pixel_ready     encoder accepts a pixel
//   frame_done      1-cycle pulse on acceptance of pixel MAX_POS
//   busy            high in LOAD/SEND/LATCH
//   dbg_state       current FSM state
// Handshake: a pixel transfers on a cycle where pixel_valid & pixel_ready;
// while valid & !ready, pixel_data and the index are held; valid never
// drops before the transfer.
// Optional: LEDS_RACER_FINISH_MARK_EN (finish mark, see pixel arbiter).
// ---------------------------------------------------------------------------
module leds_racer_frame_scheduler
  import leds_racer_pkg::*;
#(
  parameter int MAX_POS       = 109,
  parameter int LATCH_CLK_CNT = 2500,
  parameter int POS_W         = $clog2(MAX_POS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [POS_W-1:0] green_pos,
  input  logic [POS_W-1:0] red_pos,
  input  logic [POS_W-1:0] blue_pos,
  input  logic [POS_W-1:0] yellow_pos,
  output logic [23:0]      pixel_data,
  output logic             pixel_valid,
  input  logic             pixel_ready,
  output logic             frame_done,
  output logic             busy,
  output state_e           dbg_state
);

  localparam int               CNT_W    = $clog2(LATCH_CLK_CNT + 1);
  localparam logic [POS_W-1:0] LAST     = POS_W'(MAX_POS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LATCH_CLK_CNT - 1);

  state_e                state_q, state_d;
  logic [POS_W-1:0]      index_q;
  logic [CNT_W-1:0]      latch_cnt_q;
  player_e               prio_q;
  logic [3:0][POS_W-1:0] snap_q, live_pos, arb_pos;
  logic [POS_W-1:0]      arb_index;
  logic [23:0]           arb_colour;
  logic                  accept, last_accept, latch_end;

  function automatic logic [POS_W-1:0] clamp(input logic [POS_W-1:0] v);
    return (v > LAST) ? LAST : v;
  endfunction

  assign live_pos    = {clamp(yellow_pos), clamp(blue_pos), clamp(red_pos), clamp(green_pos)};
  assign accept      = (state_q == ST_SEND) && pixel_ready;
  assign last_accept = accept && (index_q == LAST);
  assign latch_end   = (state_q == ST_LATCH) && (latch_cnt_q == CNT_LAST);

  // The arbiter looks one pixel ahead so pixel_data can be a register:
  // in LOAD it colours index 0 from the live (about to be snapshotted)
  // positions; in SEND it colours the index that follows the current one.
  assign arb_index = (state_q == ST_LOAD) ? '0 : index_q + 1'b1;
  assign arb_pos   = (state_q == ST_LOAD) ? live_pos : snap_q;

  leds_racer_pixel_arbiter #(
    .MAX_POS (MAX_POS),
    .POS_W   (POS_W)
  ) u_arbiter (
    .index  (arb_index),
    .pos    (arb_pos),
    .prio   (prio_q),
    .colour (arb_colour)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (enable) state_d = ST_LOAD;
      ST_LOAD:  state_d = ST_SEND;
      ST_SEND:  if (last_accept) state_d = ST_LATCH;
      ST_LATCH: if (latch_end) state_d = enable ? ST_LOAD : ST_IDLE;
      default:  state_d = ST_LATCH;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_LATCH;
      latch_cnt_q <= '0;
      index_q     <= '0;
      prio_q      <= P_GREEN;
      snap_q      <= '0;
      pixel_data  <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_LOAD: begin
          snap_q     <= live_pos;
          index_q    <= '0;
          pixel_data <= arb_colour;
        end
        ST_SEND: begin
          if (accept) begin
            if (index_q == LAST) begin
              pixel_data  <= '0;
              prio_q      <= next_prio(prio_q);
              latch_cnt_q <= '0;
            end else begin
              index_q    <= index_q + 1'b1;
              pixel_data <= arb_colour;
            end
          end
        end
        ST_LATCH: latch_cnt_q <= latch_end ? '0 : latch_cnt_q + 1'b1;
        default: ;
      endcase
    end
  end

  assign pixel_valid = (state_q == ST_SEND);
  assign frame_done  = last_accept;
  assign busy        = (state_q != ST_IDLE);
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_leds_racer_frame_scheduler.sv
// ---------------------------------------------------------------------------
// tb_leds_racer_frame_scheduler
// Self-checking bench: a frame-level reference model builds the expected
// pixel list of each frame at the snapshot cycle and a per-cycle monitor
// compares the scheduler outputs against it. Inputs change 1 time unit
// after the rising edge; outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_leds_racer_frame_scheduler;
  import leds_racer_pkg::*;

  localparam int MAX_POS = 109;
  localparam int N       = MAX_POS + 1;
  localparam int LATCH   = 2500;
  localparam int POS_W   = 7;

  // ---------------- clock / reset / DUT ----------------
  logic             clk = 1'b0;
  logic             rst;
  logic             enable;
  logic [POS_W-1:0] green_pos, red_pos, blue_pos, yellow_pos;
  logic [23:0]      pixel_data;
  logic             pixel_valid, pixel_ready, frame_done, busy;
  state_e           dbg_state;

  always #5 clk = ~clk;

  leds_racer_frame_scheduler dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .green_pos   (green_pos),
    .red_pos     (red_pos),
    .blue_pos    (blue_pos),
    .yellow_pos  (yellow_pos),
    .pixel_data  (pixel_data),
    .pixel_valid (pixel_valid),
    .pixel_ready (pixel_ready),
    .frame_done  (frame_done),
    .busy        (busy),
    .dbg_state   (dbg_state)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int clamp_pos(input int v);
    return (v > MAX_POS) ? MAX_POS : v;
  endfunction

  // Player pl wins if it sits on the LED and is the fewest steps after prio
  // in the cyclic order G(0), R(1), B(2), Y(3).
  function automatic logic [23:0] ref_colour(input int led, input int pos[4], input int prio);
    int best = -1;
    int best_dist = 4;
    for (int pl = 0; pl < 4; pl++) begin
      if (pos[pl] == led && ((pl - prio + 4) % 4) < best_dist) begin
        best = pl;
        best_dist = (pl - prio + 4) % 4;
      end
    end
    case (best)
      0: return 24'h100000;
      1: return 24'h001000;
      2: return 24'h000010;
      3: return 24'h101000;
      default: ;
    endcase
`ifdef LEDS_RACER_FINISH_MARK_EN
    if (led == MAX_POS) return 24'h101010;
`endif
    return 24'h000000;
  endfunction

  // ---------------- scoreboard / monitor ----------------
  logic [23:0] exp_q[$];     // expected pixels of the frame in flight
  int          gap_left;     // valid-low latch cycles still expected
  bit          loading;      // next cycle is the snapshot cycle
  int          prio_cnt;     // frames completed since reset
  int          frame_cnt = 0;
  int          acc_cnt = 0;
  logic [23:0] acc_px[N];    // pixels accepted in the latest frame
  bit          prev_stall = 1'b0;
  logic [23:0] prev_data = '0;

  always @(negedge clk) begin
    if (rst) begin
      check("rst_valid", 32'(pixel_valid), 32'd0);
      check("rst_data", 32'(pixel_data), 32'd0);
      check("rst_done", 32'(frame_done), 32'd0);
      check("rst_busy", 32'(busy), 32'd1);
      exp_q.delete();
      gap_left   = LATCH;
      loading    = 1'b0;
      prio_cnt   = 0;
      prev_stall = 1'b0;
    end else if (exp_q.size() != 0) begin
      check("send_valid", 32'(pixel_valid), 32'd1);
      check("send_busy", 32'(busy), 32'd1);
      check("send_pixel", 32'(pixel_data), 32'(exp_q[0]));
      check("send_done", 32'(frame_done), 32'(pixel_ready && exp_q.size() == 1));
      if (prev_stall) check("stall_hold", 32'(pixel_data), 32'(prev_data));
      prev_stall = !pixel_ready;
      prev_data  = pixel_data;
      if (pixel_ready) begin
        acc_px[acc_cnt] = pixel_data;
        acc_cnt++;
        void'(exp_q.pop_front());
        if (exp_q.size() == 0) begin
          frame_cnt++;
          prio_cnt++;
          gap_left   = LATCH;
          prev_stall = 1'b0;
        end
      end
    end else if (loading) begin
      int p[4];
      check("load_valid", 32'(pixel_valid), 32'd0);
      check("load_busy", 32'(busy), 32'd1);
      check("load_done", 32'(frame_done), 32'd0);
      p[0] = clamp_pos(int'(green_pos));
      p[1] = clamp_pos(int'(red_pos));
      p[2] = clamp_pos(int'(blue_pos));
      p[3] = clamp_pos(int'(yellow_pos));
      for (int led = 0; led < N; led++) exp_q.push_back(ref_colour(led, p, prio_cnt % 4));
      loading = 1'b0;
      acc_cnt = 0;
    end else if (gap_left > 0) begin
      check("gap_valid", 32'(pixel_valid), 32'd0);
      check("gap_busy", 32'(busy), 32'd1);
      check("gap_done", 32'(frame_done), 32'd0);
      gap_left--;
      if (gap_left == 0 && enable) loading = 1'b1;
    end else begin
      check("idle_valid", 32'(pixel_valid), 32'd0);
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_done", 32'(frame_done), 32'd0);
      if (enable) loading = 1'b1;
    end
  end

  // ---------------- drivers ----------------
  int ready_mode = 0;  // 0 always ready, 1 toggle, 2 random

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       pixel_ready = 1'b1;
      1:       pixel_ready = !pixel_ready;
      default: pixel_ready = 1'($urandom_range(0, 1));
    endcase
  end

  task automatic set_pos(input int g, input int r, input int b, input int y);
    green_pos  = POS_W'(g);
    red_pos    = POS_W'(r);
    blue_pos   = POS_W'(b);
    yellow_pos = POS_W'(y);
  endtask

  task automatic wait_frames(input int n);
    int target = frame_cnt + n;
    int budget = 0;
    while (frame_cnt < target && budget < 12000 * n) begin
      @(posedge clk);
      budget++;
    end
    #1;
    check("frame_timeout", 32'(frame_cnt >= target), 32'd1);
  endtask

  task automatic wait_accepts(input int k);
    int budget = 0;
    while (!(exp_q.size() != 0 && acc_cnt >= k) && budget < 12000) begin
      @(posedge clk);
      budget++;
    end
    #1;
    check("accept_timeout", 32'(exp_q.size() != 0 && acc_cnt >= k), 32'd1);
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic check_race_frame(input string tag);
    int nz = 0;
    check({tag, "_count"}, 32'(acc_cnt), 32'(N));
    check({tag, "_px0"}, 32'(acc_px[0]), 32'h100000);
    check({tag, "_px5"}, 32'(acc_px[5]), 32'h001000);
    check({tag, "_px10"}, 32'(acc_px[10]), 32'h000010);
    check({tag, "_px109"}, 32'(acc_px[109]), 32'h101000);
    for (int i = 0; i < N; i++) if (acc_px[i] != 24'h0) nz++;
    check({tag, "_nonzero"}, 32'(nz), 32'd4);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int p4[4];
    logic [23:0] px3_exp[5];
    logic [23:0] last_empty;
    rst = 1'b1;
    enable = 1'b1;
    pixel_ready = 1'b1;
    set_pos(0, 5, 10, 109);

`ifdef LEDS_RACER_FINISH_MARK_EN
    last_empty = 24'h101010;
`else
    last_empty = 24'h000000;
`endif

    // Pin the model with hand-worked cases.
    p4 = '{3, 3, 3, 3};
    check("model_shared_b", 32'(ref_colour(3, p4, 2)), 32'h000010);
    check("model_shared_wrap", 32'(ref_colour(3, p4, 3)), 32'h101000);
    p4 = '{7, 2, 7, 7};
    check("model_skip_absent", 32'(ref_colour(7, p4, 1)), 32'h000010);
    check("model_empty", 32'(ref_colour(50, p4, 0)), 32'h000000);

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // 1: constant ready
    wait_frames(1);
    check_race_frame("t1");

    // 2: ready toggling every cycle
    ready_mode = 1;
    wait_frames(1);
    check_race_frame("t2");
    ready_mode = 0;

    // 3: all players share LED 3; priority rotates from green after reset
    set_pos(3, 3, 3, 3);
    pulse_reset();
    px3_exp = '{24'h100000, 24'h001000, 24'h000010, 24'h101000, 24'h100000};
    for (int f = 0; f < 5; f++) begin
      wait_frames(1);
      check($sformatf("t3_px3_f%0d", f), 32'(acc_px[3]), 32'(px3_exp[f]));
    end

    // 4: out-of-range position clamps; mid-frame change waits for next frame
    set_pos(127, 0, 0, 0);
    wait_accepts(30);
    green_pos = 7'd20;
    wait_frames(1);
    check("t4_clamp_px109", 32'(acc_px[109]), 32'h100000);
    check("t4_px20_old", 32'(acc_px[20]), 32'h000000);
    wait_frames(1);
    check("t4_px20_new", 32'(acc_px[20]), 32'h100000);
    check("t4_px109_new", 32'(acc_px[109]), 32'(last_empty));

    // 5: reset mid-frame, then enable dropped mid-frame
    wait_accepts(50);
    #2 rst = 1'b1;
    #1;
    check("t5_async_valid", 32'(pixel_valid), 32'd0);
    check("t5_async_data", 32'(pixel_data), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    wait_frames(1);
    check("t5_restart_count", 32'(acc_cnt), 32'(N));
    check("t5_restart_px0", 32'(acc_px[0]), 32'h001000);
    wait_accepts(30);
    enable = 1'b0;
    wait_frames(1);
    check("t5_full_frame", 32'(acc_cnt), 32'(N));
    repeat (LATCH + 20) @(posedge clk);
    #1;
    check("t5_idle_busy", 32'(busy), 32'd0);
    check("t5_idle_state", 32'(dbg_state), 32'(ST_IDLE));

    // 6: randomized positions (some clustered to force sharing), random ready
    enable = 1'b1;
    ready_mode = 2;
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < 4; i++) p4[i] = (f == 1) ? $urandom_range(0, 3) : $urandom_range(0, 127);
      set_pos(p4[0], p4[1], p4[2], p4[3]);
      wait_accepts($urandom_range(1, 100));
      set_pos($urandom_range(0, 127), $urandom_range(0, 127), $urandom_range(0, 127), $urandom_range(0, 127));
      wait_frames(1);
    end
    ready_mode = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
